// File: rtl/alu_execute_stage.sv
// alu_execute_stage: registered execute stage around a combinational alu.
//   Decode hands over ops via valid/ready. The alu is evaluated in the accept
//   cycle, and {result, flags, rd} is queued in a 2-entry FIFO for writeback.
//   in_ready is registered, so writeback timing never reaches back into decode.
// Optional feature: define ALU_EXEC_FORWARD_EN to forward the previous accepted
//   result into operand a/b when rs1/rs2 match its rd (x0 is never forwarded).
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        decode handshake (in_ready registered)
//   in_control, in_a, in_b   op and operands
//   in_rd, in_rs1, in_rs2    dest index (carried), source indices (forwarding)
//   out_valid/out_ready      writeback handshake on FIFO head
//   out_result, out_overflow, out_zero, out_equal, out_rd   head payload
//   ovf_sticky               any accepted op overflowed since reset

package alu_execute_pkg;
  localparam int ALU_W = 32;

  typedef logic [3:0] alu_control_t;
  localparam alu_control_t ALU_ADD  = 4'd0;
  localparam alu_control_t ALU_SUB  = 4'd1;
  localparam alu_control_t ALU_AND  = 4'd2;
  localparam alu_control_t ALU_OR   = 4'd3;
  localparam alu_control_t ALU_XOR  = 4'd4;
  localparam alu_control_t ALU_SLL  = 4'd5;
  localparam alu_control_t ALU_SRL  = 4'd6;
  localparam alu_control_t ALU_SRA  = 4'd7;
  localparam alu_control_t ALU_SLT  = 4'd8;
  localparam alu_control_t ALU_SLTU = 4'd9;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             overflow;
    logic             zero;
    logic             equal;
    logic [4:0]       rd;
  } exe_entry_t;
endpackage

module alu
  import alu_execute_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  alu_control_t   control,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   result,
  output logic           overflow,
  output logic           zero,
  output logic           equal
);
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = N'($signed(a) >>> b[4:0]);
      ALU_SLT:  result = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(N-1){1'b0}}, a < b};
      default:  result = '0;   // illegal op: zero result, zero flag follows
    endcase
    zero  = (result == '0);
    equal = (a == b);
  end
endmodule

module alu_execute_stage
  import alu_execute_pkg::*;
#(
  parameter int N     = ALU_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  alu_control_t in_control,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_overflow,
  output logic         out_zero,
  output logic         out_equal,
  output logic [4:0]   out_rd,
  output logic         ovf_sticky
);
  exe_entry_t [DEPTH-1:0] mem;
  logic [1:0]   count, count_nxt;
  logic         wr_ptr, rd_ptr;
  logic         in_ready_q;
  logic         accept, pop;
  logic [N-1:0] eff_a, eff_b;
  logic [N-1:0] alu_result;
  logic         alu_ovf, alu_zero, alu_eq;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;

`ifdef ALU_EXEC_FORWARD_EN
  logic         lr_valid;
  logic [4:0]   lr_rd;
  logic [N-1:0] lr_result;

  // x0 never forwards: its architectural value is always zero.
  always_comb begin
    eff_a = in_a;
    eff_b = in_b;
    if (lr_valid && lr_rd != 5'd0 && in_rs1 == lr_rd) eff_a = lr_result;
    if (lr_valid && lr_rd != 5'd0 && in_rs2 == lr_rd) eff_b = lr_result;
  end

  // Tracks the last accepted op only; pops leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_valid  <= 1'b0;
      lr_rd     <= '0;
      lr_result <= '0;
    end else if (accept) begin
      lr_valid  <= 1'b1;
      lr_rd     <= in_rd;
      lr_result <= alu_result;
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{in_rs1, in_rs2};
  assign eff_a = in_a;
  assign eff_b = in_b;
`endif

  alu #(.N(N)) u_alu (
    .control  (in_control),
    .a        (eff_a),
    .b        (eff_b),
    .result   (alu_result),
    .overflow (alu_ovf),
    .zero     (alu_zero),
    .equal    (alu_eq)
  );

  // accept and pop are never both set at count==2 (in_ready low) or count==0
  // (out_valid low), so the plain +1/-1 arithmetic cannot wrap.
  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem        <= '0;
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= '{result: alu_result, overflow: alu_ovf, zero: alu_zero,
                         equal: alu_eq, rd: in_rd};
        wr_ptr      <= ~wr_ptr;
        if (alu_ovf) ovf_sticky <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      // Registered from next count: a pop at full reopens in_ready one cycle later.
      in_ready_q <= (count_nxt != 2'(DEPTH));
    end
  end

  assign out_result   = mem[rd_ptr].result;
  assign out_overflow = mem[rd_ptr].overflow;
  assign out_zero     = mem[rd_ptr].zero;
  assign out_equal    = mem[rd_ptr].equal;
  assign out_rd       = mem[rd_ptr].rd;
endmodule

// File: tb/tb_alu_execute_stage.sv
module tb_alu_execute_stage;
  import alu_execute_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  alu_control_t in_control = ALU_ADD;
  logic [31:0]  in_a = '0, in_b = '0;
  logic [4:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_result;
  logic         out_overflow, out_zero, out_equal;
  logic [4:0]   out_rd;
  logic         ovf_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_equal(out_equal), .out_rd(out_rd), .ovf_sticky(ovf_sticky)
  );

  typedef struct {
    alu_control_t c;
    logic [31:0]  a, b;
    logic [4:0]   rd;
    logic [31:0]  r;
    logic         o, z, e;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic        o, z, e;
    logic [4:0]  rd;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives one op and holds it until accepted (bounded); returns at posedge+1.
  task automatic push(input alu_control_t c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    int k;
    in_control = c; in_a = a; in_b = b; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Independent reference: overflow from a 33-bit sign-extended sum.
  function automatic exp_t ref_op(input alu_control_t c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd);
    exp_t x;
    logic [32:0] s;
    x = '0;
    x.rd = rd;
    case (c)
      ALU_ADD: begin s = {a[31], a} + {b[31], b}; x.r = s[31:0]; x.o = s[32] ^ s[31]; end
      ALU_SUB: begin s = {a[31], a} - {b[31], b}; x.r = s[31:0]; x.o = s[32] ^ s[31]; end
      ALU_AND:  x.r = a & b;
      ALU_OR:   x.r = a | b;
      ALU_XOR:  x.r = a ^ b;
      ALU_SLL:  x.r = a << (b % 32);
      ALU_SRL:  x.r = a >> (b % 32);
      ALU_SRA:  x.r = (a >> (b % 32)) | (a[31] ? ~(32'hFFFF_FFFF >> (b % 32)) : 32'h0);
      ALU_SLT:  x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: x.r = (a < b) ? 32'd1 : 32'd0;
      default:  x.r = 32'd0;
    endcase
    x.z = (x.r == 32'd0);
    x.e = (a == b);
    return x;
  endfunction

  vec_t vt[14];
  exp_t sb[$];

  initial begin
    vt[0]  = '{ALU_ADD,  32'd5,         32'd7,         5'd3,  32'd12,        1'b0, 1'b0, 1'b0};
    vt[1]  = '{ALU_SUB,  32'd5,         32'd5,         5'd1,  32'd0,         1'b0, 1'b1, 1'b1};
    vt[2]  = '{ALU_SUB,  32'h8000_0000, 32'd1,         5'd2,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd4,  32'h0000_F000, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{ALU_OR,   32'h0000_00F0, 32'h0000_000F, 5'd5,  32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{ALU_XOR,  32'h0000_00AA, 32'h0000_00AA, 5'd6,  32'd0,         1'b0, 1'b1, 1'b1};
    vt[6]  = '{ALU_SLL,  32'd1,         32'd31,        5'd7,  32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{ALU_SLL,  32'd1,         32'd33,        5'd8,  32'd2,         1'b0, 1'b0, 1'b0};
    vt[8]  = '{ALU_SRL,  32'h8000_0000, 32'd4,         5'd9,  32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{ALU_SRA,  32'h8000_0000, 32'd4,         5'd10, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    vt[10] = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         5'd11, 32'd1,         1'b0, 1'b0, 1'b0};
    vt[11] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd12, 32'd0,         1'b0, 1'b1, 1'b0};
    vt[12] = '{4'd15,    32'd3,         32'd3,         5'd13, 32'd0,         1'b0, 1'b1, 1'b1};
    vt[13] = '{ALU_ADD,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0, 1'b1, 1'b0};

    // Reset state (rst high)
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_payload", 64'({out_result, out_overflow, out_zero, out_equal, out_rd}), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    do_reset();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1: single ADD, one-cycle latency
    out_ready = 1'b1;
    push(ALU_ADD, 32'd5, 32'd7, 5'd3, 5'd0, 5'd0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_head", 64'({out_result, out_overflow, out_zero, out_rd}), 64'({32'd12, 1'b0, 1'b0, 5'd3}));
    @(posedge clk); #1;
    chk("t1_drained", 64'(out_valid), 64'd0);

    // Table of single ops
    for (int i = 0; i < 14; i++) begin
      push(vt[i].c, vt[i].a, vt[i].b, vt[i].rd, 5'd0, 5'd0);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_head", i),
          64'({out_result, out_overflow, out_zero, out_equal, out_rd}),
          64'({vt[i].r, vt[i].o, vt[i].z, vt[i].e, vt[i].rd}));
    end
    @(posedge clk); #1;

    // 2: stall fills buffer, order preserved
    out_ready = 1'b0;
    push(ALU_ADD, 32'd1, 32'd1, 5'd1, 5'd0, 5'd0);
    push(ALU_SUB, 32'd5, 32'd5, 5'd2, 5'd0, 5'd0);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_head0", 64'({out_valid, out_result, out_rd}), 64'({1'b1, 32'd2, 5'd1}));
    @(posedge clk); #1;
    chk("t2_hold", 64'({out_valid, out_result, out_rd}), 64'({1'b1, 32'd2, 5'd1}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_head1", 64'({out_valid, out_result, out_zero, out_equal, out_rd}),
        64'({1'b1, 32'd0, 1'b1, 1'b1, 5'd2}));
    chk("t2_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("t2_empty", 64'(out_valid), 64'd0);

    // 3: overflow sticky
    do_reset();
    chk("t3_sticky0", 64'(ovf_sticky), 64'd0);
    push(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd7, 5'd0, 5'd0);
    chk("t3_ovf_head", 64'({out_result, out_overflow}), 64'({32'h8000_0000, 1'b1}));
    chk("t3_sticky1", 64'(ovf_sticky), 64'd1);
    push(ALU_ADD, 32'd1, 32'd2, 5'd7, 5'd0, 5'd0);
    push(ALU_AND, 32'd1, 32'd2, 5'd7, 5'd0, 5'd0);
    chk("t3_sticky_holds", 64'(ovf_sticky), 64'd1);
    do_reset();
    chk("t3_sticky_rst", 64'(ovf_sticky), 64'd0);

    // 6: reset mid-stream with full buffer
    out_ready = 1'b0;
    push(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd9, 5'd0, 5'd0);
    push(ALU_ADD, 32'd2, 32'd2, 5'd10, 5'd0, 5'd0);
    chk("t6_full", 64'({out_valid, in_ready, ovf_sticky}), 64'({1'b1, 1'b0, 1'b1}));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", 64'({out_valid, in_ready, ovf_sticky}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_release", 64'({in_ready, out_valid, out_result}), 64'({1'b1, 1'b0, 32'd0}));
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("t6_no_stale", 64'(seen), 64'd0);
    end

    // 4: random traffic vs scoreboard
    do_reset();
    begin
      int sent = 0, got = 0, cyc = 0, hold_bad = 0;
      logic        prev_stall = 1'b0;
      logic [41:0] prev_head = '0;
      logic [31:0] lr_r = '0;
      logic [4:0]  lr_d = '0;
      logic        lr_v = 1'b0;
      logic [31:0] ea, eb;
      exp_t x;
      while ((sent < 100 || sb.size() != 0) && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
        in_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
        out_ready  = ($urandom_range(0, 2) != 0);
        in_control = alu_control_t'($urandom_range(0, 15));
        in_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        in_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        in_rd  = 5'($urandom_range(0, 3));
        in_rs1 = 5'($urandom_range(0, 3));
        in_rs2 = 5'($urandom_range(0, 3));
        @(negedge clk);
        if (prev_stall && {out_result, out_overflow, out_zero, out_equal, out_rd} !== prev_head)
          hold_bad++;
        prev_stall = out_valid & ~out_ready;
        prev_head  = {out_result, out_overflow, out_zero, out_equal, out_rd};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rnd_extra_pop: out_valid=1 with empty scoreboard");
          end else begin
            x = sb.pop_front();
            chk($sformatf("rnd_pop%0d", got), 64'({out_result, out_overflow, out_zero, out_equal, out_rd}),
                64'(x));
          end
          got++;
        end
        if (in_valid && in_ready) begin
          ea = in_a; eb = in_b;
`ifdef ALU_EXEC_FORWARD_EN
          if (lr_v && lr_d != 0 && in_rs1 == lr_d) ea = lr_r;
          if (lr_v && lr_d != 0 && in_rs2 == lr_d) eb = lr_r;
`endif
          x = ref_op(in_control, ea, eb, in_rd);
          sb.push_back(x);
          lr_v = 1'b1; lr_d = in_rd; lr_r = x.r;
          sent++;
        end
      end
      in_valid = 1'b0;
      chk("rnd_count", 64'(got), 64'd100);
      chk("rnd_hold_stable", 64'(hold_bad), 64'd0);
    end

`ifdef ALU_EXEC_FORWARD_EN
    // 5: forwarding
    do_reset();
    out_ready = 1'b1;
    push(ALU_ADD, 32'd4, 32'd5, 5'd4, 5'd0, 5'd0);
    chk("t5_src", 64'(out_result), 64'd9);
    push(ALU_SLL, 32'd0, 32'd2, 5'd5, 5'd4, 5'd0);
    chk("t5_fwd", 64'(out_result), 64'd36);
    push(ALU_ADD, 32'd4, 32'd5, 5'd0, 5'd0, 5'd0);
    push(ALU_SLL, 32'd0, 32'd2, 5'd5, 5'd0, 5'd0);
    chk("t5_x0_nofwd", 64'(out_result), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
